i2c_uart_bridge_ctrl: RTL and testbench
=======================================

Name: i2c_uart_bridge_ctrl

Overview:
- Sequences bytes received by the I2C slave into the UART transmitter.
- Gates data bytes on an addressed write transaction and buffers them in a DEPTH-entry FIFO.
- Exerts I2C back-pressure through rx_ready so the slave can NACK when the FIFO is full.
- Issues one uart_start per byte under a start/busy handshake; optionally appends a terminator byte after each STOP.

Parameters:
- DEPTH, 8: FIFO entries; must be a power of 2, ≥2.
- APPEND_TERM, 1: 1 = push TERM_BYTE after a STOP that ends a transaction with ≥1 accepted byte.
- TERM_BYTE, 8'h0A: terminator value.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- i2c_start  input  1  one-cycle pulse: START or repeated START detected.
- i2c_stop  input  1  one-cycle pulse: STOP detected.
- i2c_addr_match  input  1  one-cycle pulse: received address equals slave address.
- i2c_rw  input  1  R/W bit; valid with i2c_addr_match (0 = write).
- i2c_byte  input  8  received data byte; valid with i2c_byte_valid.
- i2c_byte_valid  input  1  one-cycle pulse per data byte (never for address bytes).
- rx_ready  output  1  combinational !full; the slave ACKs only when high.
- uart_busy  input  1  UART transmitter busy.
- uart_data  output  8  byte to transmit; held stable from uart_start until uart_busy falls.
- uart_start  output  1  one-cycle request to transmit uart_data.
- fifo_level  output  $clog2(DEPTH)+1  current occupancy.
- overflow  output  1  sticky: byte or terminator dropped.
- clr_overflow  input  1  clears overflow; reset also clears it.

Behaviour:
- Reset values: uart_start=0, uart_data=0, fifo_level=0, overflow=0, rx_ready=1, FSM in IDLE, active=0, got_byte=0, term_pend=0.
- Reset mid-operation:
  - FIFO is flushed.
  - uart_start drops at the reset edge.
  - A byte already accepted by the UART is not cancelled; after reset the FSM waits in IDLE for !uart_busy before the next start.
- Transaction gate:
  - active is set on i2c_addr_match with i2c_rw=0.
  - active is cleared on i2c_addr_match with i2c_rw=1, on i2c_start, on i2c_stop, and on reset.
  - got_byte is cleared on the edge that sets active.
  - i2c_byte_valid while !active is ignored and does not set overflow.
- Push: i2c_byte_valid & active & !full writes i2c_byte and sets got_byte.
  - If full: the byte is dropped and overflow is set.
  - Full is evaluated on the pre-edge level; a same-cycle pop does not make room.
- Terminator (APPEND_TERM=1):
  - i2c_stop with active & got_byte sets term_pend.
  - Next cycle: push TERM_BYTE (overflow if full) and clear term_pend; got_byte cleared.
  - If i2c_byte_valid coincides with i2c_stop: the byte is pushed that cycle and the terminator the following cycle.
  - term_pend has priority over a new i2c_byte_valid in the same cycle; that byte is dropped with overflow. The slave cannot produce it within one cycle of STOP.
- clr_overflow and a new overflow event in the same cycle: overflow ends 1.
- FIFO:
  - Circular read/write pointers with $clog2(DEPTH) bits, wrapping at DEPTH.
  - fifo_level tracks occupancy; simultaneous push and pop leave it unchanged.
  - full = (fifo_level==DEPTH); empty = (fifo_level==0).
- UART FSM:
  - IDLE: if !empty & !uart_busy, pop the head into uart_data, pulse uart_start for 1 cycle, go to WAIT_ACK.
  - WAIT_ACK: stay until uart_busy=1, then go to WAIT_DONE.
  - WAIT_DONE: stay until uart_busy=0, then go to IDLE.
  - Exactly one uart_start per popped byte; never asserted outside IDLE exit.
- Latency: i2c_byte_valid sampled at edge N → FIFO non-empty after N → uart_start high after edge N+1 (UART idle, FIFO empty before).
- Ordering: bytes leave in I2C arrival order; the terminator follows the last byte of its transaction.
- Independence: I2C acceptance and UART draining run concurrently; no I2C event stalls the FSM.

Test Plan:
1. Basic forwarding. Stimulus: addr_match rw=0, bytes 0x67, 0x14, 0x1E, then stop; UART model busy 10 cycles per byte. Required: uart_start ×4 carrying 0x67, 0x14, 0x1E, 0x0A in order; first uart_start 2 edges after the first byte_valid; overflow=0.
2. Read-address gating. Stimulus: addr_match rw=1, two bytes, then stop. Required: no push, no terminator, fifo_level stays 0.
3. FIFO full. Stimulus: uart_busy held 1; 9 bytes with DEPTH=8. Required: fifo_level=8; rx_ready=0 after the 8th byte; 9th byte dropped; overflow=1. Then release busy: 8 starts, level returns to 0. clr_overflow → overflow=0.
4. STOP coincident with a byte, and empty STOP. Stimulus: byte 0x55 with i2c_stop in the same cycle. Required: 0x55 then 0x0A are queued. Separately, STOP with no accepted byte pushes nothing.
5. Repeated START. Stimulus: start mid-write, then bytes before a new addr_match. Required: those bytes are ignored. After addr_match rw=0, bytes resume.
6. Reset mid-transfer. Stimulus: reset while in WAIT_DONE with 3 bytes queued. Required: level=0, uart_start=0, overflow=0; no new start until uart_busy falls.

Source files
------------

// File: rtl/i2c_uart_bridge_ctrl.sv
// i2c_uart_bridge_ctrl: gates I2C write-transaction bytes into a FIFO and feeds them to a UART transmitter
module i2c_uart_bridge_ctrl #(
  parameter int DEPTH = 8,
  parameter int APPEND_TERM = 1,
  parameter logic [7:0] TERM_BYTE = 8'h0A
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i2c_start,
  input  logic                     i2c_stop,
  input  logic                     i2c_addr_match,
  input  logic                     i2c_rw,
  input  logic [7:0]               i2c_byte,
  input  logic                     i2c_byte_valid,
  output logic                     rx_ready,
  input  logic                     uart_busy,
  output logic [7:0]               uart_data,
  output logic                     uart_start,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  input  logic                     clr_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];
  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DONE} state_t;
  state_t state;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic active, got_byte, term_pend;
  logic full, empty, byte_act, byte_push, push, pop, ovf_evt, set_active;
  logic [7:0] push_data;
  always_comb begin
    full = fifo_level == FULL_LVL;
    empty = fifo_level == '0;
    byte_act = i2c_byte_valid & active;
    byte_push = byte_act & !term_pend & !full;
    push = byte_push | (term_pend & !full);
    push_data = term_pend ? TERM_BYTE : i2c_byte;
    pop = (state == IDLE) & !empty & !uart_busy;
    ovf_evt = (byte_act & (term_pend | full)) | (term_pend & full);
    set_active = i2c_addr_match & !i2c_rw & !i2c_start & !i2c_stop;
  end
  assign rx_ready = !full;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= push_data;
  // a pending terminator owns the write port for its cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_level <= '0;
      overflow <= 1'b0;
      active <= 1'b0;
      got_byte <= 1'b0;
      term_pend <= 1'b0;
    end else begin
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      fifo_level <= fifo_level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      overflow <= ovf_evt | (overflow & !clr_overflow);
      active <= (i2c_start | i2c_stop) ? 1'b0 : i2c_addr_match ? !i2c_rw : active;
      got_byte <= set_active ? 1'b0 : byte_push ? 1'b1 : term_pend ? 1'b0 : got_byte;
      term_pend <= (APPEND_TERM != 0) & i2c_stop & active & (got_byte | byte_push);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      uart_start <= 1'b0;
      uart_data <= 8'h00;
    end else begin
      uart_start <= 1'b0;
      case (state)
        IDLE: if (pop) begin
          uart_data <= mem[rd_ptr];
          uart_start <= 1'b1;
          state <= WAIT_ACK;
        end
        WAIT_ACK: if (uart_busy) state <= WAIT_DONE;
        WAIT_DONE: if (!uart_busy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_uart_bridge_ctrl.sv
// tb_i2c_uart_bridge_ctrl: directed stimulus with a queue-based reference model checked every cycle
module tb_i2c_uart_bridge_ctrl;
  localparam int DEPTH = 8;
  localparam logic [7:0] TERM = 8'h0A;
  logic clk = 0;
  logic reset = 1;
  logic i2c_start = 0, i2c_stop = 0, i2c_addr_match = 0, i2c_rw = 0;
  logic [7:0] i2c_byte = 0;
  logic i2c_byte_valid = 0;
  logic rx_ready;
  logic uart_busy = 0;
  logic [7:0] uart_data;
  logic uart_start;
  logic [3:0] fifo_level;
  logic overflow;
  logic clr_overflow = 0;
  i2c_uart_bridge_ctrl #(.DEPTH(DEPTH), .APPEND_TERM(1), .TERM_BYTE(TERM)) dut (
    .clk(clk), .reset(reset), .i2c_start(i2c_start), .i2c_stop(i2c_stop),
    .i2c_addr_match(i2c_addr_match), .i2c_rw(i2c_rw), .i2c_byte(i2c_byte),
    .i2c_byte_valid(i2c_byte_valid), .rx_ready(rx_ready), .uart_busy(uart_busy),
    .uart_data(uart_data), .uart_start(uart_start), .fifo_level(fifo_level),
    .overflow(overflow), .clr_overflow(clr_overflow)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at cycle %0d", nm, act, exp, cyc_n);
    end
  endtask
  // reference model: queue of pending bytes plus transaction/handshake flags
  logic [7:0] q[$];
  logic [7:0] log_q[$];
  bit m_ovf, m_act, m_got, m_term, m_start, owed, seen, chk_en;
  logic [7:0] m_data;
  int pre;
  bit mfull, mpop, bv, take, ovf, nterm;
  always @(posedge clk) begin
    cyc_n++;
    if (reset) begin
      q.delete();
      {m_ovf, m_act, m_got, m_term, m_start, owed, seen} = '0;
      m_data = 0;
      chk_en = 1;
    end else begin
      pre = q.size();
      mfull = pre == DEPTH;
      mpop = !owed && pre > 0 && !uart_busy;
      bv = i2c_byte_valid && m_act;
      take = bv && !m_term && !mfull;
      ovf = (bv && (m_term || mfull)) || (m_term && mfull);
      nterm = i2c_stop && m_act && (m_got || take);
      if (owed) begin
        if (!seen) seen = uart_busy;
        else if (!uart_busy) owed = 0;
      end
      m_start = mpop;
      if (mpop) begin
        m_data = q.pop_front();
        owed = 1;
        seen = 0;
      end
      if (take) q.push_back(i2c_byte);
      else if (m_term && !mfull) q.push_back(TERM);
      m_ovf = ovf || (m_ovf && !clr_overflow);
      if (i2c_addr_match && !i2c_rw && !i2c_start && !i2c_stop) m_got = 0;
      else if (take) m_got = 1;
      else if (m_term) m_got = 0;
      if (i2c_start || i2c_stop) m_act = 0;
      else if (i2c_addr_match) m_act = !i2c_rw;
      m_term = nterm;
    end
  end
  always @(negedge clk) if (chk_en) begin
    chk("level", fifo_level, q.size());
    chk("rx_ready", rx_ready, q.size() != DEPTH);
    chk("overflow", overflow, m_ovf);
    chk("uart_start", uart_start, m_start);
    chk("uart_data", uart_data, m_data);
    if (uart_start) log_q.push_back(uart_data);
  end
  // UART transmitter model: busy for 10 cycles per start, or held by force_busy
  bit force_busy = 0;
  int bcnt = 0;
  always @(negedge clk) begin
    if (uart_start) bcnt = 10;
    else if (bcnt > 0) bcnt--;
    uart_busy = force_busy || bcnt > 0;
  end
  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic addr(bit rw);
    i2c_addr_match = 1; i2c_rw = rw; tick(1);
    i2c_addr_match = 0; i2c_rw = 0;
  endtask
  task automatic bytev(logic [7:0] b, bit stp);
    i2c_byte = b; i2c_byte_valid = 1; i2c_stop = stp; tick(1);
    i2c_byte_valid = 0; i2c_stop = 0;
  endtask
  task automatic stop_p();
    i2c_stop = 1; tick(1); i2c_stop = 0;
  endtask
  task automatic start_p();
    i2c_start = 1; tick(1); i2c_start = 0;
  endtask
  task automatic wait_log(int n);
    int w = 0;
    while (log_q.size() < n && w < 400) begin tick(1); w++; end
    chk("log_count", log_q.size(), n);
  endtask
  int b, k, w, ns;
  initial begin
    tick(2);
    reset = 0;
    chk("rst_level", fifo_level, 0);
    chk("rst_rx_ready", rx_ready, 1);
    chk("rst_start", uart_start, 0);
    tick(1);
    // 1: basic forwarding with terminator
    b = log_q.size();
    addr(0);
    bytev(8'h67, 0);
    k = cyc_n;
    w = 0;
    while (!uart_start && w < 5) begin tick(1); w++; end
    chk("t1_latency", cyc_n - k, 1);
    bytev(8'h14, 0);
    bytev(8'h1E, 0);
    stop_p();
    wait_log(b + 4);
    tick(14);
    chk("t1_b0", log_q[b], 8'h67);
    chk("t1_b1", log_q[b+1], 8'h14);
    chk("t1_b2", log_q[b+2], 8'h1E);
    chk("t1_term", log_q[b+3], 8'h0A);
    chk("t1_ovf", overflow, 0);
    // 2: read address gates bytes
    b = log_q.size();
    addr(1);
    bytev(8'h11, 0);
    bytev(8'h22, 0);
    stop_p();
    tick(3);
    chk("t2_level", fifo_level, 0);
    chk("t2_log", log_q.size(), b);
    // 3: FIFO full and overflow
    force_busy = 1;
    tick(1);
    b = log_q.size();
    addr(0);
    for (int i = 0; i < 8; i++) bytev(8'h80 + 8'(i), 0);
    chk("t3_level8", fifo_level, 8);
    chk("t3_rx_ready", rx_ready, 0);
    bytev(8'h88, 0);
    chk("t3_ovf", overflow, 1);
    chk("t3_level_hold", fifo_level, 8);
    start_p();
    force_busy = 0;
    wait_log(b + 8);
    tick(14);
    chk("t3_drained", fifo_level, 0);
    for (int i = 0; i < 8; i++) chk("t3_order", log_q[b+i], 8'h80 + 8'(i));
    clr_overflow = 1; tick(1); clr_overflow = 0;
    chk("t3_clr", overflow, 0);
    // 4: stop with a byte, then an empty stop
    b = log_q.size();
    addr(0);
    bytev(8'h55, 1);
    wait_log(b + 2);
    tick(14);
    chk("t4_byte", log_q[b], 8'h55);
    chk("t4_term", log_q[b+1], 8'h0A);
    addr(0);
    stop_p();
    tick(3);
    chk("t4_empty_level", fifo_level, 0);
    chk("t4_empty_log", log_q.size(), b + 2);
    // 5: repeated start drops bytes until a new write address
    b = log_q.size();
    addr(0);
    bytev(8'h31, 0);
    start_p();
    bytev(8'h32, 0);
    bytev(8'h33, 0);
    addr(0);
    bytev(8'h34, 0);
    stop_p();
    wait_log(b + 3);
    tick(14);
    chk("t5_b0", log_q[b], 8'h31);
    chk("t5_b1", log_q[b+1], 8'h34);
    chk("t5_term", log_q[b+2], 8'h0A);
    chk("t5_count", log_q.size(), b + 3);
    // 6: reset while a byte is in flight and three are queued
    b = log_q.size();
    addr(0);
    bytev(8'hA1, 0);
    bytev(8'hA2, 0);
    bytev(8'hA3, 0);
    bytev(8'hA4, 0);
    chk("t6_level3", fifo_level, 3);
    reset = 1; tick(1); reset = 0;
    chk("t6_level0", fifo_level, 0);
    chk("t6_start0", uart_start, 0);
    chk("t6_ovf0", overflow, 0);
    chk("t6_busy", uart_busy, 1);
    addr(0);
    bytev(8'hB7, 0);
    ns = 0;
    w = 0;
    while (uart_busy && w < 40) begin
      if (uart_start) ns++;
      tick(1);
      w++;
    end
    chk("t6_no_start_busy", ns, 0);
    wait_log(b + 2);
    chk("t6_first", log_q[b], 8'hA1);
    chk("t6_after", log_q[b+1], 8'hB7);
    tick(14);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout reached at cycle %0d", cyc_n);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
